// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage hazard control for the 5-stage MIPS core.
// Tracks {valid, wa, tnew} for the E, M and W stages.
// It compares that scoreboard against the D-stage Tuse values.
// From that it produces the D-stage stall and the rs/rt forwarding selects.
// It also sequences the multiply/divide unit with a busy countdown.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               CP0 exception/eret flush, clears E and M entries
//   d_rs_addr/d_rt_addr D-stage source register numbers
//   d_tuse_rs/d_tuse_rt source Tuse (0..2), 3 = source not read
//   d_wa/d_we/d_tnew    D-stage destination, write enable, Tnew on entering E
//   d_is_md             D instruction touches the MD unit or HI/LO
//   d_md_start/d_md_div D instruction starts an MD op / the op is a divide
//   stall               freeze PC and F/D, bubble into E
//   fwd_rs_sel/rt_sel   0=GRF 1=E 2=M 3=W
//   md_busy             MD countdown non-zero
//
// Build option: define SCOREBOARD_MD_EN to include the MD countdown.
// Without it, md_busy is tied 0 and the MD inputs are ignored.
module hazard_scoreboard #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic [4:0] d_rs_addr,
    input  logic [4:0] d_rt_addr,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wa,
    input  logic       d_we,
    input  logic [1:0] d_tnew,
    input  logic       d_is_md,
    input  logic       d_md_start,
    input  logic       d_md_div,
    output logic       stall,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic       md_busy
);

    logic       r_e_v;
    logic [4:0] r_e_wa;
    logic [1:0] r_e_tnew;
    logic       r_m_v;
    logic [4:0] r_m_wa;
    logic [1:0] r_m_tnew;
    // W entries always carry tnew 0, so only valid and wa are kept.
    logic       r_w_v;
    logic [4:0] r_w_wa;

    logic       w_md_stall;
    logic [2:0] w_rs;
    logic [2:0] w_rt;

    // Returns {stall, sel} for one source; the youngest match wins.
    function automatic logic [2:0] resolve(
        input logic [4:0] a,
        input logic [1:0] tuse
    );
        logic hit_e;
        logic hit_m;
        logic hit_w;
        logic [2:0] res;
        hit_e = r_e_v && (r_e_wa == a) && (a != 5'd0);
        hit_m = r_m_v && (r_m_wa == a) && (a != 5'd0);
        hit_w = r_w_v && (r_w_wa == a) && (a != 5'd0);
        res = 3'd0;
        if (tuse != 2'd3) begin
            if (hit_e) begin
                res[2]   = (r_e_tnew > tuse);
                res[1:0] = (r_e_tnew == 2'd0) ? 2'd1 : 2'd0;
            end else if (hit_m) begin
                res[2]   = (r_m_tnew > tuse);
                res[1:0] = (r_m_tnew == 2'd0) ? 2'd2 : 2'd0;
            end else if (hit_w) begin
                res = {1'b0, 2'd3};
            end
        end
        return res;
    endfunction

    always_comb begin
        w_rs = resolve(d_rs_addr, d_tuse_rs);
        w_rt = resolve(d_rt_addr, d_tuse_rt);
    end

    assign stall      = w_rs[2] | w_rt[2] | w_md_stall;
    assign fwd_rs_sel = w_rs[1:0];
    assign fwd_rt_sel = w_rt[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_v    <= 1'b0;
            r_e_wa   <= 5'd0;
            r_e_tnew <= 2'd0;
            r_m_v    <= 1'b0;
            r_m_wa   <= 5'd0;
            r_m_tnew <= 2'd0;
            r_w_v    <= 1'b0;
            r_w_wa   <= 5'd0;
        end else begin
            // W always takes M's old content, even on a flush.
            r_w_v  <= r_m_v;
            r_w_wa <= r_m_wa;
            r_m_wa <= r_e_wa;
            r_m_tnew <= (r_e_tnew == 2'd0) ? 2'd0 : r_e_tnew - 2'd1;
            r_e_wa   <= d_wa;
            r_e_tnew <= d_tnew;
            if (flush) begin
                r_m_v <= 1'b0;
                r_e_v <= 1'b0;
            end else begin
                r_m_v <= r_e_v;
                r_e_v <= d_we & ~stall;
            end
        end
    end

`ifdef SCOREBOARD_MD_EN
    localparam logic [4:0] LP_MULT = 5'(MULT_CYCLES);
    localparam logic [4:0] LP_DIV  = 5'(DIV_CYCLES);

    logic [4:0] r_md_cnt;

    assign w_md_stall = d_is_md & (r_md_cnt != 5'd0);
    assign md_busy    = (r_md_cnt != 5'd0);

    // Flush does not abort an in-flight MD operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt <= 5'd0;
        end else if (d_md_start & ~stall & ~flush) begin
            r_md_cnt <= d_md_div ? LP_DIV : LP_MULT;
        end else if (r_md_cnt != 5'd0) begin
            r_md_cnt <= r_md_cnt - 5'd1;
        end
    end
`else
    logic w_unused_md;

    assign w_unused_md = ^{d_is_md, d_md_start, d_md_div};
    assign w_md_stall  = 1'b0;
    assign md_busy     = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed bench for hazard_scoreboard.
// Expected outputs are queued per step and popped at the sample point.
module tb_hazard_scoreboard;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef SCOREBOARD_MD_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, flush;
    logic [4:0] d_rs_addr, d_rt_addr, d_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_we, d_is_md, d_md_start, d_md_div;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    typedef struct {
        logic       st;
        logic [1:0] rs;
        logic [1:0] rt;
        logic       bz;
    } exp_t;

    exp_t exp_q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    hazard_scoreboard #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_wa(d_wa), .d_we(d_we), .d_tnew(d_tnew),
        .d_is_md(d_is_md), .d_md_start(d_md_start), .d_md_div(d_md_div),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic dset(input logic [4:0] rs, input logic [1:0] trs,
                        input logic [4:0] rt, input logic [1:0] trt,
                        input logic [4:0] wa, input logic we,
                        input logic [1:0] tn);
        d_rs_addr = rs; d_tuse_rs = trs;
        d_rt_addr = rt; d_tuse_rt = trt;
        d_wa = wa; d_we = we; d_tnew = tn;
        d_is_md = 1'b0; d_md_start = 1'b0; d_md_div = 1'b0;
    endtask

    task automatic mdset(input logic is_md, input logic st, input logic dv);
        d_is_md = is_md; d_md_start = st; d_md_div = dv;
    endtask

    // Inputs are already driven; compare at negedge, then pass the edge.
    task automatic step(input string tag, input logic est,
                        input logic [1:0] ers, input logic [1:0] ert,
                        input logic ebz);
        exp_t e;
        exp_q.push_back('{st: est, rs: ers, rt: ert, bz: ebz});
        @(negedge clk);
        e = exp_q.pop_front();
        n_run++;
        assert (stall === e.st) else begin
            n_fail++;
            $error("FAIL %s.stall got %0b exp %0b", tag, stall, e.st);
        end
        n_run++;
        assert (fwd_rs_sel === e.rs) else begin
            n_fail++;
            $error("FAIL %s.rs got %0d exp %0d", tag, fwd_rs_sel, e.rs);
        end
        n_run++;
        assert (fwd_rt_sel === e.rt) else begin
            n_fail++;
            $error("FAIL %s.rt got %0d exp %0d", tag, fwd_rt_sel, e.rt);
        end
        n_run++;
        assert (md_busy === e.bz) else begin
            n_fail++;
            $error("FAIL %s.busy got %0b exp %0b", tag, md_busy, e.bz);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        dset(0, 3, 0, 3, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        dset(8, 0, 9, 0, 0, 0, 0);
        step("rst", 0, 0, 0, 0);

        // lw $8 (tnew 2) then beq on $8 (tuse 0): E, M stall, then W
        dset(29, 1, 0, 3, 8, 1, 2);
        step("lw8", 0, 0, 0, 0);
        dset(8, 0, 0, 0, 0, 0, 0);
        step("beq_e", 1, 0, 0, 0);
        step("beq_m", 1, 0, 0, 0);
        step("beq_w", 0, 3, 0, 0);

        // lw $9 then addu reading $9 at tuse 1: one stall
        dset(0, 3, 0, 3, 9, 1, 2);
        step("lw9", 0, 0, 0, 0);
        dset(9, 1, 10, 1, 11, 1, 1);
        step("addu_e", 1, 0, 0, 0);
        step("addu_m", 0, 0, 0, 0);

        // addu $12 then ori $13 reading $12
        dset(0, 1, 0, 3, 12, 1, 1);
        step("addu12", 0, 0, 0, 0);
        dset(12, 1, 0, 3, 13, 1, 1);
        step("ori_e", 0, 0, 0, 0);
        dset(12, 1, 13, 1, 0, 0, 0);
        step("two_src", 0, 2, 0, 0);
        dset(13, 0, 12, 0, 0, 0, 0);
        step("m_and_w", 0, 2, 3, 0);

        // lw writing $0, consumer reads $0
        dset(0, 3, 0, 3, 0, 1, 2);
        step("lw0", 0, 0, 0, 0);
        dset(0, 0, 0, 0, 0, 0, 0);
        step("rd0", 0, 0, 0, 0);

        // E has priority over M for the same register
        dset(0, 3, 0, 3, 14, 1, 1);
        step("p_addu", 0, 0, 0, 0);
        dset(0, 3, 0, 3, 14, 1, 2);
        step("p_lw", 0, 0, 0, 0);
        dset(14, 1, 0, 3, 0, 0, 0);
        step("prio_e", 1, 0, 0, 0);
        step("prio_m", 0, 0, 0, 0);

        // lw $15, lw $16, then flush; the D write to $17 is dropped
        dset(0, 3, 0, 3, 15, 1, 2);
        step("f_lw15", 0, 0, 0, 0);
        dset(0, 3, 0, 3, 16, 1, 2);
        step("f_lw16", 0, 0, 0, 0);
        dset(15, 0, 16, 0, 17, 1, 0);
        flush = 1'b1;
        step("f_pre", 1, 0, 0, 0);
        flush = 1'b0;
        dset(15, 0, 16, 0, 0, 0, 0);
        step("f_post", 0, 3, 0, 0);
        dset(15, 3, 17, 0, 0, 0, 0);
        step("f_drop", 0, 0, 0, 0);

        // mult then mflo held in D
        dset(0, 3, 0, 3, 0, 0, 0);
        mdset(1, 1, 0);
        step("mult", 0, 0, 0, 0);
        dset(0, 3, 0, 3, 8, 1, 1);
        mdset(1, 0, 0);
        for (int i = 0; i < MC; i++) step("mflo_m", MD, 0, 0, MD);
        step("mflo_m_go", 0, 0, 0, 0);

        // div then mflo held in D
        dset(0, 3, 0, 3, 0, 0, 0);
        mdset(1, 1, 1);
        step("div", 0, 0, 0, 0);
        dset(0, 3, 0, 3, 8, 1, 1);
        mdset(1, 0, 0);
        for (int i = 0; i < DC; i++) step("mflo_d", MD, 0, 0, MD);
        step("mflo_d_go", 0, 0, 0, 0);

        // reset in the middle of a divide with md_cnt at 7
        dset(0, 3, 0, 3, 0, 0, 0);
        mdset(1, 1, 1);
        step("div2", 0, 0, 0, 0);
        dset(0, 3, 0, 3, 0, 0, 0);
        step("nonmd_10", 0, 0, 0, MD);
        step("nonmd_9", 0, 0, 0, MD);
        dset(0, 3, 0, 3, 18, 1, 2);
        step("lw18", 0, 0, 0, MD);
        dset(18, 0, 0, 3, 0, 0, 0);
        mdset(1, 0, 0);
        reset = 1'b1;
        step("rst_pre", 1, 0, 0, MD);
        reset = 1'b0;
        step("rst_post", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
